// File: rtl/dct2d_pass_sequencer_if.sv
// Handshake and engine-control bundle for dct2d_pass_sequencer.
// master: the sequencer side; slave: the environment (source, engine, sink).
interface dct2d_pass_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             x_load;
    logic             sel_pass;
    logic             mm_rst;
    logic             mm_done;
    logic             z_load;
    logic             y_load;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic             err_clr;
    logic [CNT_W-1:0] blk_cnt;

    modport master (
        input  in_valid, mm_done, out_ready, err_clr,
        output in_ready, x_load, sel_pass, mm_rst, z_load, y_load,
               out_valid, err, blk_cnt
    );

    modport slave (
        output in_valid, mm_done, out_ready, err_clr,
        input  in_ready, x_load, sel_pass, mm_rst, z_load, y_load,
               out_valid, err, blk_cnt
    );
endinterface

// File: rtl/dct2d_pass_sequencer.sv
// Two-pass 8x8 2-D DCT sequencer: pass 1 Z = X*D^T, pass 2 Y = D*Z on one
// shared matrix-multiply engine, with valid/ready I/O and a RUN watchdog.
// Optional macro DCT_LAT_MON_EN adds the lat_cyc x_load-to-y_load monitor.
module dct2d_pass_sequencer #(
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    dct2d_pass_sequencer_if.master bus
`ifdef DCT_LAT_MON_EN
    ,
    output logic [15:0] lat_cyc
`endif
);

    localparam int CYC_W = $clog2((TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE,
        P1_RST,
        P1_RUN,
        P2_RST,
        P2_RUN,
        OUT,
        ERR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CYC_W-1:0] cyc_q;
    logic [CNT_W-1:0] blk_q;
    logic             sel_q;

    logic in_ready;
    logic x_load;
    logic sel_pass;
    logic mm_rst;
    logic z_load;
    logic y_load;
    logic out_valid;
    logic done_ok;
    logic rst_end;
    logic run_end;

    // done is only trusted from the second RUN cycle on (stale-done guard)
    assign done_ok = bus.mm_done && (cyc_q != '0);
    assign rst_end = (cyc_q == CYC_W'(RST_CYC - 1));
    assign run_end = (cyc_q == CYC_W'(TIMEOUT - 1));
    assign x_load  = bus.in_valid & in_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-state outputs; done beats watchdog expiry
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        sel_pass  = sel_q;
        mm_rst    = 1'b1;
        z_load    = 1'b0;
        y_load    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = P1_RST;
            end
            P1_RST: begin
                sel_pass = 1'b0;
                if (rst_end) state_d = P1_RUN;
            end
            P1_RUN: begin
                sel_pass = 1'b0;
                mm_rst   = 1'b0;
                if (done_ok) begin
                    z_load  = 1'b1;
                    state_d = P2_RST;
                end else if (run_end) begin
                    state_d = ERR;
                end
            end
            P2_RST: begin
                sel_pass = 1'b1;
                if (rst_end) state_d = P2_RUN;
            end
            P2_RUN: begin
                sel_pass = 1'b1;
                mm_rst   = 1'b0;
                if (done_ok) begin
                    y_load  = 1'b1;
                    state_d = OUT;
                end else if (run_end) begin
                    state_d = ERR;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            ERR: begin
                if (bus.err_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-state cycle counter: RST length and RUN watchdog, cleared on every transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (state_d != state_q) begin
            cyc_q <= '0;
        end else if (state_q inside {P1_RST, P1_RUN, P2_RST, P2_RUN}) begin
            cyc_q <= cyc_q + CYC_W'(1);
        end
    end

    // Operand select memory so sel_pass holds outside the pass states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_q <= 1'b0;
        else       sel_q <= sel_pass;
    end

    // Completed-block counter, stepped on the output handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              blk_q <= '0;
        else if (out_valid && bus.out_ready)    blk_q <= blk_q + CNT_W'(1);
    end

`ifdef DCT_LAT_MON_EN
    logic [15:0] lat_run;

    // Latency monitor: lat_run counts cycles already elapsed since x_load;
    // the y_load cycle itself is added when publishing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_run <= '0;
            lat_cyc <= '0;
        end else begin
            if (x_load)              lat_run <= 16'd1;
            else if (lat_run != '1)  lat_run <= lat_run + 16'd1;
            if (y_load)              lat_cyc <= (lat_run == '1) ? '1 : lat_run + 16'd1;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.x_load    = x_load;
    assign bus.sel_pass  = sel_pass;
    assign bus.mm_rst    = mm_rst;
    assign bus.z_load    = z_load;
    assign bus.y_load    = y_load;
    assign bus.out_valid = out_valid;
    assign bus.err       = (state_q == ERR);
    assign bus.blk_cnt   = blk_q;

endmodule

// File: tb/tb_dct2d_pass_sequencer.sv
// Self-checking bench for dct2d_pass_sequencer (RST_CYC=2, TIMEOUT=64, CNT_W=2).
// Engine model raises mm_done on its K-th low-mm_rst cycle (or never / always).
module tb_dct2d_pass_sequencer;

    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef DCT_LAT_MON_EN
    logic [15:0] lat_cyc;
`endif

    dct2d_pass_sequencer_if #(.CNT_W(CNT_W)) bus ();

    dct2d_pass_sequencer #(
        .RST_CYC(2),
        .TIMEOUT(64),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef DCT_LAT_MON_EN
        ,
        .lat_cyc(lat_cyc)
`endif
    );

    always #5 clk = ~clk;

    // Engine model: 0 = done on K-th low cycle, 1 = never done, 2 = done tied high
    int eng_mode = 0;
    int eng_k    = 10;
    int low_cnt  = 0;

    // Count consecutive low-mm_rst cycles of the model engine
    always @(posedge clk) low_cnt <= bus.mm_rst ? 0 : low_cnt + 1;

    assign bus.mm_done = (eng_mode == 2) ||
                         (eng_mode == 0 && !bus.mm_rst && low_cnt == eng_k - 1);

    int npass  = 0;
    int ntotal = 0;
    int model_cnt = 0;
    int exp_q[$];

    typedef struct {
        int mode;
        int k;
        int odelay;
        int exp_first_low;
        int exp_low;
        int exp_z;
        int exp_y;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block: x_load at cycle 0, cycles counted from there
    task automatic run_block(input vec_t v);
        int z_at = -1, y_at = -1, ov_at = -1, hs_at = -1;
        int zc = 0, yc = 0, lowc = 0, first_low = -1;
        int sel_z = -1, sel_y = -1;
        int bp_ok = 1;
        int cnt_before;
        int exp_blk;
        cnt_before = int'(bus.blk_cnt);
        eng_mode = v.mode;
        eng_k    = v.k;
        bus.in_valid = 1'b1;
        #2;
        chk("x_load", int'(bus.x_load), 1);
        // 2-bit block counter wraps modulo 4
        model_cnt = (model_cnt + 1) % 4;
        exp_q.push_back(model_cnt);
        for (int cyc = 0; cyc < 400 && hs_at < 0; cyc++) begin
            if (cyc > 0) begin
                tick();
                // keep offering a new X while waiting on the sink: must not be taken
                bus.in_valid = (ov_at >= 0);
                #2;
            end
            if (!bus.mm_rst) begin
                lowc++;
                if (first_low < 0) first_low = cyc;
            end
            if (bus.z_load) begin zc++; z_at = cyc; sel_z = int'(bus.sel_pass); end
            if (bus.y_load) begin yc++; y_at = cyc; sel_y = int'(bus.sel_pass); end
            if (bus.out_valid) begin
                if (ov_at < 0) ov_at = cyc;
                if (cyc >= ov_at + v.odelay) begin
                    bus.out_ready = 1'b1;
                    hs_at = cyc;
                end else if (bus.in_ready || bus.x_load || int'(bus.blk_cnt) != cnt_before) begin
                    bp_ok = 0;
                end
            end
        end
        chk("handshake_seen", int'(hs_at >= 0), 1);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #2;
        exp_blk = exp_q.pop_front();
        chk("blk_cnt", int'(bus.blk_cnt), exp_blk);
        chk("in_ready_after", int'(bus.in_ready), 1);
        chk("out_valid_after", int'(bus.out_valid), 0);
        chk("z_load_count", zc, 1);
        chk("z_load_cycle", z_at, v.exp_z);
        chk("y_load_count", yc, 1);
        chk("y_load_cycle", y_at, v.exp_y);
        chk("out_valid_cycle", ov_at, v.exp_y + 1);
        chk("handshake_cycle", hs_at, v.exp_y + 1 + v.odelay);
        chk("mm_rst_low_cycles", lowc, v.exp_low);
        chk("mm_rst_first_low", first_low, v.exp_first_low);
        chk("sel_at_z", sel_z, 0);
        chk("sel_at_y", sel_y, 1);
        chk("backpressure_hold", bp_ok, 1);
`ifdef DCT_LAT_MON_EN
        chk("lat_cyc", int'(lat_cyc), v.exp_y + 1);
`endif
    endtask

    // Global safety net
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int err_at;
        int bad;
        vec_t v0;

        // mode, K, out_ready delay, first low, low count, z_load, y_load
        vecs[0] = '{0, 10, 0, 3, 20, 12, 24};
        vecs[1] = '{0, 10, 5, 3, 20, 12, 24};
        vecs[2] = '{2, 10, 0, 3,  4,  4,  8};
        vecs[3] = '{0,  5, 1, 3, 10,  7, 14};
        vecs[4] = '{0,  2, 0, 3,  4,  4,  8};
        vecs[5] = '{0, 64, 0, 3, 128, 66, 132};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;

        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_mm_rst", int'(bus.mm_rst), 1);
        chk("rst_sel_pass", int'(bus.sel_pass), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_blk_cnt", int'(bus.blk_cnt), 0);
        chk("rst_x_load", int'(bus.x_load), 0);
        chk("rst_z_y_load", int'(bus.z_load | bus.y_load), 0);
`ifdef DCT_LAT_MON_EN
        chk("rst_lat_cyc", int'(lat_cyc), 0);
`endif

        // blk_cnt sequence across the table: 1, 2, 3, 0, 1, 2
        for (int i = 0; i < 6; i++) run_block(vecs[i]);

        // Hung engine: 64 P1_RUN cycles (3..66), ERR from cycle 67
        eng_mode = 1;
        bus.in_valid = 1'b1;
        #2;
        chk("hung_x_load", int'(bus.x_load), 1);
        err_at = -1;
        bad = 0;
        for (int cyc = 0; cyc < 200 && err_at < 0; cyc++) begin
            if (cyc > 0) begin
                tick();
                bus.in_valid = 1'b0;
                #2;
            end
            if (bus.z_load || bus.y_load) bad = 1;
            if (bus.err) err_at = cyc;
        end
        chk("hung_err_cycle", err_at, 67);
        chk("hung_no_load", bad, 0);
        chk("err_mm_rst", int'(bus.mm_rst), 1);
        chk("err_in_ready", int'(bus.in_ready), 0);
        chk("err_out_valid", int'(bus.out_valid), 0);
        tick();
        bus.in_valid = 1'b1;
        #2;
        chk("err_sticky", int'(bus.err), 1);
        chk("err_no_x_load", int'(bus.x_load), 0);
        tick();
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        #2;
        chk("err_before_clr_edge", int'(bus.err), 1);
        tick();
        bus.err_clr = 1'b0;
        #2;
        chk("err_cleared", int'(bus.err), 0);
        chk("clr_in_ready", int'(bus.in_ready), 1);
        chk("clr_blk_cnt", int'(bus.blk_cnt), model_cnt);

        // Reset during P2_RUN (cycle 16 of a K=10 block): abort with no y_load
        eng_mode = 0;
        eng_k    = 10;
        bus.in_valid = 1'b1;
        #2;
        chk("abort_x_load", int'(bus.x_load), 1);
        bad = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            bus.in_valid = 1'b0;
            #2;
            if (bus.y_load) bad = 1;
        end
        chk("abort_in_p2_run", int'({bus.mm_rst, bus.sel_pass}), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_mm_rst", int'(bus.mm_rst), 1);
        chk("abort_blk_cnt", int'(bus.blk_cnt), 0);
        chk("abort_sel_pass", int'(bus.sel_pass), 0);
        chk("abort_err", int'(bus.err), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.y_load || bus.z_load) bad = 1;
        end
        reset = 1'b0;
        model_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            #2;
            if (bus.y_load || bus.out_valid) bad = 1;
            tick();
        end
        chk("abort_no_y_load", bad, 0);
        #2;

        // Next block after the abort completes normally
        v0 = vecs[0];
        run_block(v0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
